oc_dispatch_arbiter: RTL and testbench
======================================

// Module: oc_dispatch_arbiter
// PURPOSE
//   Produces the per-unit one-hot dispatch grants (ALU_Grt, MEM_Grt) that steer the
//   4:1 collector-to-execution dispatch mux. It arbitrates among 4 operand collectors
//   with independent round-robin pointers per execution unit. Dispatch_OC returns the
//   grant to each collector so the winning collector frees its entry.
// PARAMETERS
//   N_OC   4    number of operand collectors; fixed at 4 to match the 4-bit grant buses
//   CNT_W  16   width of the statistics counters (OC_DISPATCH_STATS_EN only)
// PORTS
//   clk            in   1      single clock; all state updates on the rising edge
//   rst            in   1      synchronous, active-high reset
//   Ready_OC       in   4      collector i holds an instruction with all operands collected
//   IsMem_OC       in   4      collector i holds LD/ST (MemRead|MemWrite); else ALU; ignored when Ready_OC[i]=0
//   ALU_Ready      in   1      ALU pipe accepts an instruction this cycle
//   MEM_Ready      in   1      MEM pipe accepts an instruction this cycle
//   ALU_Grt        out  4      one-hot ALU grant, or 0
//   MEM_Grt        out  4      one-hot MEM grant, or 0
//   Dispatch_OC    out  4      ALU_Grt|MEM_Grt; collector i clears its entry at the next edge
//   ALU_Issue_Cnt  out  CNT_W  ALU dispatches since reset
//   MEM_Issue_Cnt  out  CNT_W  MEM dispatches since reset
//   MEM_Stall_Cnt  out  CNT_W  cycles with a MEM request pending while MEM_Ready=0
// BEHAVIOUR
//   - Request vectors: ReqALU = Ready_OC & ~IsMem_OC; ReqMEM = Ready_OC & IsMem_OC.
//     They are disjoint, so no collector is granted to both units.
//   - Grants are combinational from the requests, the Ready inputs and the registered
//     pointers. Latency is 0 cycles, request to grant, in the same cycle.
//   - ALU_Grt = RR(ReqALU, ptr_alu) when ALU_Ready=1, else 0.
//   - MEM_Grt = RR(ReqMEM, ptr_mem) when MEM_Ready=1, else 0.
//   - RR(req, p): scan indices p, p+1, p+2, p+3 (mod 4); the first set bit wins.
//   - Pointer update (2-bit each):
//     - on a grant to index i, ptr <= (i+1) mod 4; wrap 3 -> 0;
//     - with no grant, the pointer holds.
//   - Handshake:
//     - a collector keeps Ready_OC high until it sees Dispatch_OC[i]=1 at a clock edge;
//     - it deasserts Ready_OC in the following cycle;
//     - the arbiter does not track outstanding grants; correctness relies on this rule.
//   - Invariants, checked by assertion:
//     - $onehot0(ALU_Grt) and $onehot0(MEM_Grt);
//     - (ALU_Grt & MEM_Grt) == 0;
//     - Grt is a subset of the matching Req vector.
//   - Empty: all requests 0 -> both grants 0, pointers hold.
//   - Unit blocked: the unit's grant is 0, its pointer holds, the other unit is unaffected.
//   - Reset:
//     - rst=1 forces ALU_Grt, MEM_Grt and Dispatch_OC to 0 in the same cycle;
//     - ptr_alu and ptr_mem reset to 0; all counters reset to 0;
//     - a reset asserted mid-stream drops no state beyond these registers.
// CONFIGURATION
//   OC_DISPATCH_STATS_EN defined:
//     - ALU_Issue_Cnt and MEM_Issue_Cnt increment by 1 per cycle with a nonzero grant to that unit;
//     - MEM_Stall_Cnt increments when |ReqMEM and MEM_Ready=0;
//     - all three saturate at 2^CNT_W-1 and do not wrap.
//   OC_DISPATCH_STATS_EN undefined:
//     - no counter registers are built;
//     - the three count ports are tied to 0;
//     - arbitration is identical in both builds.
// TESTING
//   1 Reset, then Ready_OC=1111, IsMem_OC=0000, ALU_Ready=1 held for 5 cycles
//     -> ALU_Grt = 0001, 0010, 0100, 1000, 0001; MEM_Grt=0 throughout.
//   2 Reset, then Ready_OC=1111, IsMem_OC=0101, both units ready
//     -> ALU_Grt=0010, MEM_Grt=0001, Dispatch_OC=0011;
//     -> next cycle ALU_Grt=1000, MEM_Grt=0100.
//   3 Ready_OC=0100, IsMem_OC=0100, MEM_Ready=0 for 3 cycles
//     -> MEM_Grt=0 and ptr_mem unchanged (MEM_Stall_Cnt=3 with stats);
//     -> MEM_Ready=1 -> MEM_Grt=0100, then ptr_mem=3.
//   4 Wrap: after an ALU grant to 2, Ready_OC=1001, IsMem_OC=0000, with collectors
//     obeying the clear-on-dispatch handshake -> ALU_Grt=1000, then 0001, then 0000.
//   5 Mid-stream: rst=1 for 1 cycle while Ready_OC=1111
//     -> ALU_Grt=MEM_Grt=0 during rst; first grant after release is 0001; counters read 0.
//   6 Build without OC_DISPATCH_STATS_EN, rerun scenario 2
//     -> identical grants; all count ports read 0.

Source files
------------

// File: rtl/oc_dispatch_arbiter.sv
// oc_dispatch_arbiter: grants one ready operand collector per cycle to the ALU pipe
// and one to the MEM pipe. Each unit has its own round-robin pointer.
// Optional statistics counters are built when OC_DISPATCH_STATS_EN is defined;
// otherwise the count ports read 0.
module oc_dispatch_arbiter #(
    parameter int unsigned N_OC  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_OC-1:0]  Ready_OC,
    input  logic [N_OC-1:0]  IsMem_OC,
    input  logic             ALU_Ready,
    input  logic             MEM_Ready,
    output logic [N_OC-1:0]  ALU_Grt,
    output logic [N_OC-1:0]  MEM_Grt,
    output logic [N_OC-1:0]  Dispatch_OC,
    output logic [CNT_W-1:0] ALU_Issue_Cnt,
    output logic [CNT_W-1:0] MEM_Issue_Cnt,
    output logic [CNT_W-1:0] MEM_Stall_Cnt
);

    localparam int unsigned PW = $clog2(N_OC);

    logic [N_OC-1:0] req_alu;
    logic [N_OC-1:0] req_mem;
    logic [PW-1:0]   ptr_alu_q, ptr_alu_d;
    logic [PW-1:0]   ptr_mem_q, ptr_mem_d;

    // Scan from the pointer upward (mod N_OC); the first requester wins.
    function automatic logic [N_OC-1:0] rr_pick(input logic [N_OC-1:0] req,
                                                input logic [PW-1:0]   ptr);
        logic [N_OC-1:0] g;
        logic [PW-1:0]   idx;
        g = '0;
        for (int unsigned k = 0; k < N_OC; k++) begin
            idx = ptr + PW'(k);
            if (g == '0 && req[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Index of the set bit of a one-hot vector.
    function automatic logic [PW-1:0] oh_enc(input logic [N_OC-1:0] oh);
        logic [PW-1:0] e;
        e = '0;
        for (int unsigned k = 0; k < N_OC; k++) begin
            if (oh[k]) e = PW'(k);
        end
        return e;
    endfunction

    // Requests split by unit, grants gated by unit readiness and reset.
    always_comb begin
        req_alu     = Ready_OC & ~IsMem_OC;
        req_mem     = Ready_OC &  IsMem_OC;
        ALU_Grt     = '0;
        MEM_Grt     = '0;
        if (!rst && ALU_Ready) ALU_Grt = rr_pick(req_alu, ptr_alu_q);
        if (!rst && MEM_Ready) MEM_Grt = rr_pick(req_mem, ptr_mem_q);
        Dispatch_OC = ALU_Grt | MEM_Grt;
    end

    // Next pointer: one past the winner, or hold when the unit granted nothing.
    always_comb begin
        ptr_alu_d = ptr_alu_q;
        ptr_mem_d = ptr_mem_q;
        if (|ALU_Grt) ptr_alu_d = oh_enc(ALU_Grt) + PW'(1);
        if (|MEM_Grt) ptr_mem_d = oh_enc(MEM_Grt) + PW'(1);
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_alu_q <= '0;
            ptr_mem_q <= '0;
        end else begin
            ptr_alu_q <= ptr_alu_d;
            ptr_mem_q <= ptr_mem_d;
        end
    end

`ifdef OC_DISPATCH_STATS_EN
    logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters.
    always_comb begin
        alu_cnt_d   = alu_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (|ALU_Grt && alu_cnt_q != '1) alu_cnt_d = alu_cnt_q + CNT_W'(1);
        if (|MEM_Grt && mem_cnt_q != '1) mem_cnt_d = mem_cnt_q + CNT_W'(1);
        if (|req_mem && !MEM_Ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_cnt_q   <= '0;
            mem_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            alu_cnt_q   <= alu_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ALU_Issue_Cnt = alu_cnt_q;
    assign MEM_Issue_Cnt = mem_cnt_q;
    assign MEM_Stall_Cnt = stall_cnt_q;
`else
    assign ALU_Issue_Cnt = '0;
    assign MEM_Issue_Cnt = '0;
    assign MEM_Stall_Cnt = '0;
`endif

    // Grant invariants: one-hot-or-zero, disjoint, and only to requesters.
    a_alu_onehot: assert property (@(posedge clk) $onehot0(ALU_Grt));
    a_mem_onehot: assert property (@(posedge clk) $onehot0(MEM_Grt));
    a_disjoint:   assert property (@(posedge clk) (ALU_Grt & MEM_Grt) == '0);
    a_alu_subset: assert property (@(posedge clk) (ALU_Grt & ~req_alu) == '0);
    a_mem_subset: assert property (@(posedge clk) (MEM_Grt & ~req_mem) == '0);

endmodule

// File: tb/tb_oc_dispatch_arbiter.sv
// Directed bench for oc_dispatch_arbiter. Expected count values follow the
// OC_DISPATCH_STATS_EN setting of the build (0 when the counters are not built).
module tb_oc_dispatch_arbiter;

    localparam int unsigned CW = 3;
`ifdef OC_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    Ready_OC, IsMem_OC;
    logic          ALU_Ready, MEM_Ready;
    logic [3:0]    ALU_Grt, MEM_Grt, Dispatch_OC;
    logic [CW-1:0] ALU_Issue_Cnt, MEM_Issue_Cnt, MEM_Stall_Cnt;

    int n_vec = 0;
    int n_err = 0;

    oc_dispatch_arbiter #(.N_OC(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Ready_OC(Ready_OC), .IsMem_OC(IsMem_OC),
        .ALU_Ready(ALU_Ready), .MEM_Ready(MEM_Ready),
        .ALU_Grt(ALU_Grt), .MEM_Grt(MEM_Grt), .Dispatch_OC(Dispatch_OC),
        .ALU_Issue_Cnt(ALU_Issue_Cnt), .MEM_Issue_Cnt(MEM_Issue_Cnt),
        .MEM_Stall_Cnt(MEM_Stall_Cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ec(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] s1_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst = 1'b1; Ready_OC = '0; IsMem_OC = '0; ALU_Ready = 1'b0; MEM_Ready = 1'b0;
        step();
        do_reset();

        // Reset state
        #1;
        check("rst_alu_grt", ALU_Grt, 4'b0000);
        check("rst_mem_grt", MEM_Grt, 4'b0000);
        check("rst_alu_cnt", ALU_Issue_Cnt, 0);
        check("rst_stall_cnt", MEM_Stall_Cnt, 0);

        // 1: ALU-only rotation, then saturation of the issue counter
        Ready_OC = 4'b1111; IsMem_OC = 4'b0000; ALU_Ready = 1'b1; MEM_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("s1_alu_%0d", i), ALU_Grt, s1_exp[i]);
            check($sformatf("s1_mem_%0d", i), MEM_Grt, 4'b0000);
            step();
        end
        check("s1_alu_cnt5", ALU_Issue_Cnt, ec(5));
        for (int i = 0; i < 4; i++) step();
        check("s1_alu_cnt_sat", ALU_Issue_Cnt, ec(7));
        check("s1_mem_cnt", MEM_Issue_Cnt, 0);

        // 2: mixed requests, both units ready
        do_reset();
        Ready_OC = 4'b1111; IsMem_OC = 4'b0101; ALU_Ready = 1'b1; MEM_Ready = 1'b1;
        #1;
        check("s2_alu_a", ALU_Grt, 4'b0010);
        check("s2_mem_a", MEM_Grt, 4'b0001);
        check("s2_disp_a", Dispatch_OC, 4'b0011);
        step();
        check("s2_alu_b", ALU_Grt, 4'b1000);
        check("s2_mem_b", MEM_Grt, 4'b0100);
        check("s2_disp_b", Dispatch_OC, 4'b1100);
        step();
        check("s2_alu_cnt", ALU_Issue_Cnt, ec(2));
        check("s2_mem_cnt", MEM_Issue_Cnt, ec(2));

        // 3: MEM blocked for 3 cycles, then released
        do_reset();
        Ready_OC = 4'b0100; IsMem_OC = 4'b0100; ALU_Ready = 1'b1; MEM_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("s3_mem_blk_%0d", i), MEM_Grt, 4'b0000);
            check($sformatf("s3_alu_blk_%0d", i), ALU_Grt, 4'b0000);
            step();
        end
        check("s3_stall_cnt", MEM_Stall_Cnt, ec(3));
        MEM_Ready = 1'b1;
        #1;
        check("s3_mem_rel", MEM_Grt, 4'b0100);
        step();
        check("s3_stall_hold", MEM_Stall_Cnt, ec(3));
        check("s3_mem_cnt", MEM_Issue_Cnt, ec(1));
        Ready_OC = 4'b1111; IsMem_OC = 4'b1111;
        #1;
        check("s3_ptr_mem3", MEM_Grt, 4'b1000);
        check("s3_alu_none", ALU_Grt, 4'b0000);

        // 4: pointer wrap with clear-on-dispatch collectors
        do_reset();
        Ready_OC = 4'b0100; IsMem_OC = 4'b0000; ALU_Ready = 1'b1; MEM_Ready = 1'b1;
        #1;
        check("s4_alu_2", ALU_Grt, 4'b0100);
        step();
        Ready_OC = 4'b1001;
        #1;
        check("s4_alu_3", ALU_Grt, 4'b1000);
        step();
        Ready_OC = 4'b0001;
        #1;
        check("s4_alu_wrap", ALU_Grt, 4'b0001);
        step();
        Ready_OC = 4'b0000;
        #1;
        check("s4_alu_empty", ALU_Grt, 4'b0000);
        check("s4_mem_empty", MEM_Grt, 4'b0000);

        // 5: mid-stream reset
        Ready_OC = 4'b1111;
        step();
        rst = 1'b1;
        #1;
        check("s5_alu_in_rst", ALU_Grt, 4'b0000);
        check("s5_mem_in_rst", MEM_Grt, 4'b0000);
        check("s5_disp_in_rst", Dispatch_OC, 4'b0000);
        step();
        rst = 1'b0;
        #1;
        check("s5_alu_first", ALU_Grt, 4'b0001);
        check("s5_alu_cnt0", ALU_Issue_Cnt, 0);
        check("s5_mem_cnt0", MEM_Issue_Cnt, 0);

        // Unit blocked: ALU not ready, MEM unaffected
        ALU_Ready = 1'b0; IsMem_OC = 4'b0101;
        #1;
        check("s6_alu_blk", ALU_Grt, 4'b0000);
        check("s6_mem_go", MEM_Grt, 4'b0001);
        step();
        ALU_Ready = 1'b1;
        #1;
        check("s6_alu_ptr_held", ALU_Grt, 4'b0010);
        check("s6_mem_next", MEM_Grt, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
